// File: rtl/drawbridge_sequencer_pkg.sv
// Shared state codes, motor encodings and the Moore output decode for the
// drawbridge sequencer.
package drawbridge_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_WARN  = 3'b001,
    S_RAISE = 3'b010,
    S_OPEN  = 3'b011,
    S_LOWER = 3'b100,
    S_FAULT = 3'b101
  } state_t;

  localparam logic [1:0] MT_OFF  = 2'b00;
  localparam logic [1:0] MT_UP   = 2'b01;
  localparam logic [1:0] MT_DOWN = 2'b10;

  typedef struct packed {
    logic [1:0] mt;
    logic       al;
    logic       tfl;
    logic       fault;
  } outs_t;

  // Illegal codes decode to a safe "motor off, road closed" pattern.
  function automatic outs_t decode_outs(input state_t s);
    outs_t o;
    o = '{mt: MT_OFF, al: 1'b1, tfl: 1'b1, fault: 1'b0};
    case (s)
      S_IDLE:  o = '{mt: MT_OFF,  al: 1'b0, tfl: 1'b0, fault: 1'b0};
      S_WARN:  o = '{mt: MT_OFF,  al: 1'b1, tfl: 1'b1, fault: 1'b0};
      S_RAISE: o = '{mt: MT_UP,   al: 1'b1, tfl: 1'b1, fault: 1'b0};
      S_OPEN:  o = '{mt: MT_OFF,  al: 1'b0, tfl: 1'b1, fault: 1'b0};
      S_LOWER: o = '{mt: MT_DOWN, al: 1'b1, tfl: 1'b1, fault: 1'b0};
      S_FAULT: o = '{mt: MT_OFF,  al: 1'b1, tfl: 1'b1, fault: 1'b1};
      default: o = '{mt: MT_OFF,  al: 1'b1, tfl: 1'b1, fault: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/drawbridge_sequencer_if.sv
// Sensor/command bundle between the bridge plant (or bench) and the sequencer.
interface drawbridge_sequencer_if;
  import drawbridge_sequencer_pkg::*;

  logic       BoatReq;
  logic       RoadClear;
  logic       LimUp;
  logic       LimDown;
  logic       BoatPassed;
  logic [1:0] MT;
  logic       AL;
  logic       TFL;
  logic       Fault;
  logic [2:0] State;

  modport master (
    output BoatReq, RoadClear, LimUp, LimDown, BoatPassed,
    input  MT, AL, TFL, Fault, State
  );

  modport slave (
    input  BoatReq, RoadClear, LimUp, LimDown, BoatPassed,
    output MT, AL, TFL, Fault, State
  );
endinterface

// File: rtl/drawbridge_sequencer_state_timer.sv
// Per-state cycle counter: cleared on demand, otherwise counts up and
// saturates at all-ones.
module drawbridge_sequencer_state_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/drawbridge_sequencer.sv
// Drawbridge sequencer: timed warn/raise/hold/lower cycle with motor timeouts,
// limit-switch consistency checks and a latched fault state.
module drawbridge_sequencer
  import drawbridge_sequencer_pkg::*;
#(
  parameter int CLEAR_CYC   = 8,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  drawbridge_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  state_t           next_state;
  logic             open_flag;
  logic             timer_clear;
  logic             timer_en;
  logic [CNT_W-1:0] cnt;
  outs_t            outs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Both limits active at once is physically impossible: treat as a sensor
  // fault ahead of any other decision.
  always_comb begin
    next_state = state;
    if (bus.LimUp && bus.LimDown) begin
      next_state = S_FAULT;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.LimDown)    next_state = S_LOWER;
          else if (bus.BoatReq) next_state = S_WARN;
        end
        S_WARN: begin
          if (!bus.BoatReq)                          next_state = S_IDLE;
          else if ((cnt >= CLEAR_LAST) && bus.RoadClear) next_state = S_RAISE;
        end
        S_RAISE: begin
          if (bus.LimUp)                 next_state = S_OPEN;
          else if (cnt == TIMEOUT_LAST)  next_state = S_FAULT;
        end
        S_OPEN: begin
          if (!bus.LimUp)                           next_state = S_FAULT;
          else if (open_flag && (cnt == HOLD_LAST)) next_state = S_LOWER;
        end
        S_LOWER: begin
          if (bus.LimDown)               next_state = S_IDLE;
          else if (cnt == TIMEOUT_LAST)  next_state = S_FAULT;
        end
        S_FAULT: next_state = S_FAULT;
        default: next_state = S_FAULT;
      endcase
    end
  end

  always_comb begin
    outs      = decode_outs(state);
    bus.MT    = outs.mt;
    bus.AL    = outs.al;
    bus.TFL   = outs.tfl;
    bus.Fault = outs.fault;
    bus.State = state;
  end

  // Boat-passed flag lives only while we stay in OPEN; the hold timer is
  // pinned at zero until the pulse has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_flag <= 1'b0;
    end else begin
      open_flag <= (state == S_OPEN) && (next_state == S_OPEN) &&
                   (open_flag || bus.BoatPassed);
    end
  end

  assign timer_clear = (next_state != state) || ((state == S_OPEN) && !open_flag);
  assign timer_en    = (state != S_FAULT);

  drawbridge_sequencer_state_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .count  (cnt)
  );

endmodule

// File: tb/tb_drawbridge_sequencer.sv
// Scoreboard bench for the drawbridge sequencer: expected states are queued
// as stimulus is applied and compared once the DUT has had its clock edge.
module tb_drawbridge_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [2:0] st_q[$];

  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] WARN  = 3'b001;
  localparam logic [2:0] RAISE = 3'b010;
  localparam logic [2:0] OPEN  = 3'b011;
  localparam logic [2:0] LOWER = 3'b100;
  localparam logic [2:0] FLT   = 3'b101;

  drawbridge_sequencer_if bus ();

  drawbridge_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {MT, AL, TFL, Fault} for each state, straight from the state table.
  function automatic logic [4:0] outs_of(input logic [2:0] st);
    case (st)
      IDLE:    return 5'b00_0_0_0;
      WARN:    return 5'b00_1_1_0;
      RAISE:   return 5'b01_1_1_0;
      OPEN:    return 5'b00_0_1_0;
      LOWER:   return 5'b10_1_1_0;
      FLT:     return 5'b00_1_1_1;
      default: return 5'b11_1_1_1;
    endcase
  endfunction

  task automatic pop_cmp();
    string      t;
    logic [2:0] st;
    logic [4:0] o;
    if (st_q.size() == 0) begin
      check("queue_underflow", 8'd1, 8'd0);
      return;
    end
    t  = tag_q.pop_front();
    st = st_q.pop_front();
    o  = outs_of(st);
    check({t, "/state"}, 8'(bus.State), 8'(st));
    check({t, "/mt"},    8'(bus.MT),    8'(o[4:3]));
    check({t, "/al"},    8'(bus.AL),    8'(o[2]));
    check({t, "/tfl"},   8'(bus.TFL),   8'(o[1]));
    check({t, "/fault"}, 8'(bus.Fault), 8'(o[0]));
  endtask

  task automatic tick(input string tag, input logic [2:0] st);
    tag_q.push_back(tag);
    st_q.push_back(st);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic expect_now(input string tag, input logic [2:0] st);
    tag_q.push_back(tag);
    st_q.push_back(st);
    pop_cmp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    expect_now("rst_async", IDLE);
    repeat (2) @(posedge clk);
    #1;
    expect_now("rst_held", IDLE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_now("rst_release", IDLE);
  endtask

  initial begin
    bus.BoatReq    = 1'b0;
    bus.RoadClear  = 1'b1;
    bus.LimUp      = 1'b0;
    bus.LimDown    = 1'b1;
    bus.BoatPassed = 1'b0;
    do_reset();

    // Normal cycle
    tick("n_idle", IDLE);
    bus.BoatReq = 1'b1;
    tick("n_warn_in", WARN);
    for (int i = 0; i < 7; i++) tick("n_warn", WARN);
    tick("n_raise_in", RAISE);
    bus.LimDown = 1'b0;
    for (int i = 0; i < 4; i++) tick("n_raise", RAISE);
    bus.LimUp = 1'b1;
    tick("n_open_in", OPEN);
    bus.BoatReq = 1'b0;
    for (int i = 0; i < 3; i++) tick("n_open_wait", OPEN);
    bus.BoatPassed = 1'b1;
    tick("n_open_bp", OPEN);
    bus.BoatPassed = 1'b0;
    for (int i = 0; i < 3; i++) tick("n_open_hold", OPEN);
    tick("n_lower_in", LOWER);
    bus.LimUp = 1'b0;
    bus.BoatPassed = 1'b1;
    tick("n_lower_bp_ignored", LOWER);
    bus.BoatPassed = 1'b0;
    tick("n_lower", LOWER);
    bus.LimDown = 1'b1;
    tick("n_idle_back", IDLE);

    // Road blocked, then raise timeout into the latched fault
    bus.BoatReq   = 1'b1;
    bus.RoadClear = 1'b0;
    tick("rb_warn_in", WARN);
    for (int i = 0; i < 20; i++) tick("rb_warn_blocked", WARN);
    bus.RoadClear = 1'b1;
    tick("rb_raise", RAISE);
    bus.LimDown = 1'b0;
    for (int i = 0; i < 31; i++) tick("to_raise", RAISE);
    tick("to_fault", FLT);
    bus.BoatReq = 1'b0;
    bus.LimDown = 1'b1;
    tick("flt_hold1", FLT);
    bus.LimUp = 1'b1;
    tick("flt_hold2", FLT);
    bus.LimUp   = 1'b0;
    bus.BoatReq = 1'b1;
    tick("flt_hold3", FLT);
    bus.BoatReq = 1'b0;
    do_reset();

    // Abort during WARN
    bus.BoatReq = 1'b1;
    tick("ab_warn1", WARN);
    tick("ab_warn2", WARN);
    tick("ab_warn3", WARN);
    bus.BoatReq = 1'b0;
    tick("ab_idle", IDLE);
    tick("ab_idle2", IDLE);

    // Sensor conflict while OPEN
    bus.BoatReq = 1'b1;
    tick("sc_warn_in", WARN);
    for (int i = 0; i < 7; i++) tick("sc_warn", WARN);
    tick("sc_raise", RAISE);
    bus.LimDown = 1'b0;
    bus.LimUp   = 1'b1;
    tick("sc_open", OPEN);
    bus.LimDown = 1'b1;
    tick("sc_fault", FLT);

    // Homing after reset with the deck not down, then async reset mid-LOWER
    bus.BoatReq = 1'b0;
    bus.LimUp   = 1'b0;
    bus.LimDown = 1'b0;
    do_reset();
    tick("hm_lower_in", LOWER);
    tick("hm_lower", LOWER);
    rst = 1'b1;
    #1;
    expect_now("hm_async_mt_off", IDLE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_now("hm_idle_after", IDLE);
    tick("hm_relower", LOWER);
    tick("hm_relower2", LOWER);
    bus.BoatReq = 1'b1;
    tick("hm_no_reverse", LOWER);
    bus.LimDown = 1'b1;
    tick("hm_down_idle", IDLE);
    tick("hm_served_warn", WARN);
    bus.BoatReq = 1'b0;
    tick("hm_final_idle", IDLE);

    check("scoreboard_empty", 8'(st_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
